// File: rtl/lz_token_encoder.sv
// LZ token to symbol encoder: literals pass through, matches split into length then distance symbols.
// Latency 1 cycle token->symbol; tok_rdy drops while a held symbol is blocked or a distance is pending.
module lz_token_encoder (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       tok_vld,
    output logic       tok_rdy,
    input  logic       tok_is_match,
    input  logic [3:0] tok_lit,
    input  logic [8:0] tok_len,
    input  logic [8:0] tok_dist,
    output logic       sym_vld,
    input  logic       sym_rdy,
    output logic [4:0] sym,
    output logic [5:0] sym_ext,
    output logic       err,
    output logic [8:0] hist_cnt
);

    typedef enum logic [1:0] {IDLE, LIT, LEN, DIST} state_t;

    state_t     state_q, state_d;
    logic [4:0] sym_q, sym_d;
    logic [5:0] ext_q, ext_d;
    logic [4:0] dsym_q, dsym_d;
    logic [5:0] dext_q, dext_d;
    logic       err_q, err_d;
    logic [8:0] hist_q, hist_d;

    logic [4:0] lcode, dcode;
    logic [8:0] lbase, dbase;
    logic [5:0] lext, dext;
    logic       illegal;
    logic       accept;
    logic [9:0] hist_sum;

    // Length code table: highest base not exceeding the length wins.
    always_comb begin
        lcode = 5'd17;
        lbase = 9'd6;
        if      (tok_len >= 9'd130) begin lcode = 5'd28; lbase = 9'd130; end
        else if (tok_len >= 9'd64)  begin lcode = 5'd27; lbase = 9'd64;  end
        else if (tok_len >= 9'd50)  begin lcode = 5'd26; lbase = 9'd50;  end
        else if (tok_len >= 9'd34)  begin lcode = 5'd25; lbase = 9'd34;  end
        else if (tok_len >= 9'd26)  begin lcode = 5'd24; lbase = 9'd26;  end
        else if (tok_len >= 9'd22)  begin lcode = 5'd23; lbase = 9'd22;  end
        else if (tok_len >= 9'd18)  begin lcode = 5'd22; lbase = 9'd18;  end
        else if (tok_len >= 9'd14)  begin lcode = 5'd21; lbase = 9'd14;  end
        else if (tok_len >= 9'd12)  begin lcode = 5'd20; lbase = 9'd12;  end
        else if (tok_len >= 9'd10)  begin lcode = 5'd19; lbase = 9'd10;  end
        else if (tok_len >= 9'd8)   begin lcode = 5'd18; lbase = 9'd8;   end
        lext = 6'((tok_len - lbase) >> 1);
    end

    always_comb begin
        dcode = 5'd0;
        dbase = 9'd2;
        if      (tok_dist >= 9'd450) begin dcode = 5'd15; dbase = 9'd450; end
        else if (tok_dist >= 9'd386) begin dcode = 5'd14; dbase = 9'd386; end
        else if (tok_dist >= 9'd322) begin dcode = 5'd13; dbase = 9'd322; end
        else if (tok_dist >= 9'd258) begin dcode = 5'd12; dbase = 9'd258; end
        else if (tok_dist >= 9'd194) begin dcode = 5'd11; dbase = 9'd194; end
        else if (tok_dist >= 9'd130) begin dcode = 5'd10; dbase = 9'd130; end
        else if (tok_dist >= 9'd66)  begin dcode = 5'd9;  dbase = 9'd66;  end
        else if (tok_dist >= 9'd34)  begin dcode = 5'd8;  dbase = 9'd34;  end
        else if (tok_dist >= 9'd26)  begin dcode = 5'd7;  dbase = 9'd26;  end
        else if (tok_dist >= 9'd18)  begin dcode = 5'd6;  dbase = 9'd18;  end
        else if (tok_dist >= 9'd14)  begin dcode = 5'd5;  dbase = 9'd14;  end
        else if (tok_dist >= 9'd10)  begin dcode = 5'd4;  dbase = 9'd10;  end
        else if (tok_dist >= 9'd8)   begin dcode = 5'd3;  dbase = 9'd8;   end
        else if (tok_dist >= 9'd6)   begin dcode = 5'd2;  dbase = 9'd6;   end
        else if (tok_dist >= 9'd4)   begin dcode = 5'd1;  dbase = 9'd4;   end
        dext = 6'((tok_dist - dbase) >> 1);
    end

    assign illegal = tok_len[0] || (tok_len < 9'd6) || (tok_len > 9'd256) ||
                     tok_dist[0] || (tok_dist < 9'd2) || (tok_dist > hist_q);

    assign tok_rdy = (state_q == IDLE) ||
                     (((state_q == LIT) || (state_q == DIST)) && sym_rdy);
    assign accept  = tok_vld && tok_rdy;
    assign hist_sum = {1'b0, hist_q} + (tok_is_match ? {1'b0, tok_len} : 10'd1);

    always_comb begin
        state_d = state_q;
        sym_d   = sym_q;
        ext_d   = ext_q;
        dsym_d  = dsym_q;
        dext_d  = dext_q;
        err_d   = 1'b0;
        hist_d  = hist_q;
        if (accept) begin
            if (!tok_is_match) begin
                state_d = LIT;
                sym_d   = {1'b0, tok_lit};
                ext_d   = 6'd0;
                hist_d  = hist_sum[9] ? 9'd511 : hist_sum[8:0];
            end else if (illegal) begin
                // Acceptance only happens once any held symbol is drained.
                state_d = IDLE;
                err_d   = 1'b1;
            end else begin
                state_d = LEN;
                sym_d   = lcode;
                ext_d   = lext;
                dsym_d  = dcode;
                dext_d  = dext;
                hist_d  = hist_sum[9] ? 9'd511 : hist_sum[8:0];
            end
        end else if (sym_rdy) begin
            if (state_q == LEN) begin
                state_d = DIST;
                sym_d   = dsym_q;
                ext_d   = dext_q;
            end else if (state_q != IDLE) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            state_q <= IDLE;
            sym_q   <= 5'd0;
            ext_q   <= 6'd0;
            dsym_q  <= 5'd0;
            dext_q  <= 6'd0;
            err_q   <= 1'b0;
            hist_q  <= 9'd0;
        end else begin
            state_q <= state_d;
            sym_q   <= sym_d;
            ext_q   <= ext_d;
            dsym_q  <= dsym_d;
            dext_q  <= dext_d;
            err_q   <= err_d;
            hist_q  <= hist_d;
        end
    end

    assign sym_vld  = (state_q != IDLE);
    assign sym      = sym_q;
    assign sym_ext  = ext_q;
    assign err      = err_q;
    assign hist_cnt = hist_q;

endmodule

// File: tb/tb_lz_token_encoder.sv
// Directed bench for lz_token_encoder: hand-computed symbols, history counts, error pulses and resets.
module tb_lz_token_encoder;

    logic       clk = 1'b0;
    logic       rst, en, tok_vld, tok_rdy, tok_is_match, sym_vld, sym_rdy, err;
    logic [3:0] tok_lit;
    logic [8:0] tok_len, tok_dist, hist_cnt;
    logic [4:0] sym;
    logic [5:0] sym_ext;

    int ntests = 0;
    int nfail  = 0;

    lz_token_encoder dut (
        .clk(clk), .rst(rst), .en(en),
        .tok_vld(tok_vld), .tok_rdy(tok_rdy), .tok_is_match(tok_is_match),
        .tok_lit(tok_lit), .tok_len(tok_len), .tok_dist(tok_dist),
        .sym_vld(sym_vld), .sym_rdy(sym_rdy), .sym(sym), .sym_ext(sym_ext),
        .err(err), .hist_cnt(hist_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic lit(input logic [3:0] v);
        tok_vld = 1'b1; tok_is_match = 1'b0; tok_lit = v;
    endtask

    task automatic mat(input logic [8:0] l, input logic [8:0] d);
        tok_vld = 1'b1; tok_is_match = 1'b1; tok_len = l; tok_dist = d;
    endtask

    task automatic sym_chk(input string tag, input logic [4:0] s, input logic [5:0] e);
        chk({tag, "_vld"}, 32'(sym_vld), 32'd1);
        chk({tag, "_sym"}, 32'(sym), 32'(s));
        chk({tag, "_ext"}, 32'(sym_ext), 32'(e));
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; tok_vld = 1'b0; tok_is_match = 1'b0;
        tok_lit = 4'd0; tok_len = 9'd0; tok_dist = 9'd0; sym_rdy = 1'b1;
        step(); step();
        chk("rst_vld", 32'(sym_vld), 32'd0);
        chk("rst_sym", 32'(sym), 32'd0);
        chk("rst_ext", 32'(sym_ext), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_hist", 32'(hist_cnt), 32'd0);
        chk("rst_rdy", 32'(tok_rdy), 32'd1);
        rst = 1'b0;

        // Single literal
        lit(4'hA); step();
        sym_chk("lit_a", 5'd10, 6'd0);
        chk("lit_a_hist", 32'(hist_cnt), 32'd1);
        tok_vld = 1'b0; step();
        chk("lit_drain_vld", 32'(sym_vld), 32'd0);

        // Seven more literals back-to-back, then the shortest legal match
        for (int i = 0; i < 7; i++) begin
            lit(4'(i)); step();
            sym_chk("lit_stream", 5'(i), 6'd0);
        end
        chk("lit8_hist", 32'(hist_cnt), 32'd8);
        mat(9'd6, 9'd2); step();
        sym_chk("m6_len", 5'd17, 6'd0);
        chk("m6_hist", 32'(hist_cnt), 32'd14);
        chk("m6_len_rdy", 32'(tok_rdy), 32'd0);
        tok_vld = 1'b0; step();
        sym_chk("m6_dist", 5'd0, 6'd0);
        step();
        chk("m6_idle", 32'(sym_vld), 32'd0);

        // Saturate history: 14+256 = 270, +256 clips to 511
        for (int i = 0; i < 2; i++) begin
            mat(9'd256, 9'd2); step();
            tok_vld = 1'b0; step(); step();
        end
        chk("sat_hist", 32'(hist_cnt), 32'd511);
        mat(9'd256, 9'd510); step();
        sym_chk("max_len", 5'd28, 6'd63);
        chk("max_hist", 32'(hist_cnt), 32'd511);
        tok_vld = 1'b0; step();
        sym_chk("max_dist", 5'd15, 6'd30);
        // Next match is taken while the distance symbol drains
        mat(9'd16, 9'd12); step();
        sym_chk("m16_len", 5'd21, 6'd1);
        tok_vld = 1'b0; step();
        sym_chk("m16_dist", 5'd4, 6'd1);
        chk("m16_hist", 32'(hist_cnt), 32'd511);
        step();

        // en low clears like reset
        en = 1'b0; step(); en = 1'b1;
        chk("en_clr_hist", 32'(hist_cnt), 32'd0);
        for (int i = 0; i < 4; i++) begin
            lit(4'hF); step();
        end
        tok_vld = 1'b0; step();
        chk("hist4", 32'(hist_cnt), 32'd4);

        // Illegal matches: dist beyond history, odd length, too short
        mat(9'd6, 9'd6); step();
        tok_vld = 1'b0;
        chk("ill_dist_err", 32'(err), 32'd1);
        chk("ill_dist_vld", 32'(sym_vld), 32'd0);
        chk("ill_dist_hist", 32'(hist_cnt), 32'd4);
        step();
        chk("ill_err_pulse", 32'(err), 32'd0);
        mat(9'd7, 9'd2); step();
        tok_vld = 1'b0;
        chk("ill_odd_err", 32'(err), 32'd1);
        chk("ill_odd_vld", 32'(sym_vld), 32'd0);
        step();
        mat(9'd4, 9'd2); step();
        tok_vld = 1'b0;
        chk("ill_short_err", 32'(err), 32'd1);
        chk("ill_short_hist", 32'(hist_cnt), 32'd4);
        step();

        // Backpressure in LEN: length symbol held, no tokens accepted
        sym_rdy = 1'b0;
        mat(9'd8, 9'd4); step();
        lit(4'h3);
        for (int i = 0; i < 5; i++) begin
            sym_chk("bp_len", 5'd18, 6'd0);
            chk("bp_rdy", 32'(tok_rdy), 32'd0);
            step();
        end
        chk("bp_hist", 32'(hist_cnt), 32'd12);
        sym_rdy = 1'b1; step();
        sym_chk("bp_dist", 5'd1, 6'd0);
        step();
        sym_chk("bp_next_lit", 5'd3, 6'd0);
        chk("bp_lit_hist", 32'(hist_cnt), 32'd13);
        tok_vld = 1'b0; step();

        // Reset mid-match drops the pending distance, even with a token offered
        mat(9'd6, 9'd2); step();
        sym_chk("rstm_len", 5'd17, 6'd0);
        rst = 1'b1; lit(4'h5); step();
        rst = 1'b0; tok_vld = 1'b0;
        chk("rstm_vld", 32'(sym_vld), 32'd0);
        chk("rstm_hist", 32'(hist_cnt), 32'd0);
        chk("rstm_rdy", 32'(tok_rdy), 32'd1);
        step();
        chk("rstm_no_dist", 32'(sym_vld), 32'd0);

        // Same with en low
        lit(4'h1); step(); step();
        tok_vld = 1'b0; step();
        mat(9'd6, 9'd2); step();
        sym_chk("enm_len", 5'd17, 6'd0);
        tok_vld = 1'b0; en = 1'b0; step();
        en = 1'b1;
        chk("enm_vld", 32'(sym_vld), 32'd0);
        chk("enm_hist", 32'(hist_cnt), 32'd0);
        step();
        chk("enm_no_dist", 32'(sym_vld), 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/lz_token_encoder.md
LZ_TOKEN_ENCODER -- requirements
Module: lz_token_encoder

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 en  in  1  block enable; low = synchronous clear equal to reset.
REQ-005 tok_vld  in  1  upstream token valid.
REQ-006 tok_rdy  out  1  token accepted when tok_vld & tok_rdy at a rising edge.
REQ-007 tok_is_match  in  1  1 = match token (len, dist); 0 = literal token.
REQ-008 tok_lit  in  4  literal nibble; ignored when tok_is_match=1.
REQ-009 tok_len  in  9  match length in nibbles.
REQ-010 tok_dist  in  9  match distance in nibbles.
REQ-011 sym_vld  out  1  symbol valid; registered.
REQ-012 sym_rdy  in  1  downstream ready; symbol consumed when sym_vld & sym_rdy.
REQ-013 sym  out  5  symbol: literal 0..15, length code 17..28, distance code 0..15.
REQ-014 sym_ext  out  6  extra-bits value; 0 for literals.
REQ-015 err  out  1  one-cycle pulse on an illegal match token.
REQ-016 hist_cnt  out  9  nibbles produced since clear, saturating at 511.

Function
REQ-017 State machine states: IDLE (no symbol held), LIT (literal held), LEN (length symbol held, distance pending), DIST (distance symbol held).
REQ-018 sym_vld=1 in LIT/LEN/DIST; sym_vld=0 in IDLE.
REQ-019 tok_rdy = IDLE | ((LIT|DIST) & sym_rdy); tok_rdy=0 in LEN.
REQ-020 Literal accept: next state LIT; sym={1'b0,tok_lit}; sym_ext=0; sym_vld high the cycle after acceptance.
REQ-021 Legal match accept: next state LEN; sym=length code, sym_ext=length ext; distance code/ext registered alongside.
REQ-022 LEN & sym_rdy: move to DIST; present the stored distance code/ext.
REQ-023 Length and distance symbols are always back-to-back, with no literal between them.
REQ-024 (LIT|DIST) & sym_rdy with no token accepted: move to IDLE; with a token accepted: load the new token directly (1 symbol/cycle throughput).
REQ-025 While sym_vld=1 & sym_rdy=0: sym, sym_ext and state are held stable.
REQ-026 Length encoding: code c is chosen where base(c) <= len < base(c+1); ext=(len-base(c))/2.
REQ-027 Length bases: 17:6, 18:8, 19:10, 20:12, 21:14, 22:18, 23:22, 24:26, 25:34, 26:50, 27:64, 28:130 (max len 256, ext 63).
REQ-028 Distance encoding: same rule as REQ-026.
REQ-029 Distance bases: 0:2, 1:4, 2:6, 3:8, 4:10, 5:14, 6:18, 7:26, 8:34, 9:66, 10:130, 11:194, 12:258, 13:322, 14:386, 15:450 (max dist 510, ext 30).
REQ-030 A match is illegal if any holds: len odd; len<6; len>256; dist odd; dist<2; dist>hist_cnt (hist_cnt value at the accepting edge).
REQ-031 Illegal match: token consumed; no symbol emitted; err=1 for exactly the next cycle; hist_cnt unchanged.
REQ-032 Illegal match: next state IDLE, unless the held symbol is not drained, in which case the state is held.
REQ-033 hist_cnt update at acceptance: +1 per literal; +len per legal match; saturates at 511, no wrap.
REQ-034 Encoding arithmetic is 9-bit unsigned; ext is computed as (value-base)>>1.

Reset
REQ-035 rst=1 or en=0 at an edge: state=IDLE, sym_vld=0, sym=0, sym_ext=0, err=0, hist_cnt=0, stored distance=0.
REQ-036 A pending distance symbol is discarded when reset hits mid-match.
REQ-037 Reset and en=0 take priority over any simultaneous handshake.

Verification
REQ-038 Literal tok_lit=0xA, sym_rdy=1 -> next cycle sym=10, sym_ext=0, sym_vld=1, hist_cnt=1.
REQ-039 8 literals, then match len=6 dist=2 -> (17,0) then (0,0) on consecutive cycles; hist_cnt=14.
REQ-040 hist_cnt=511, match len=256 dist=510 -> (28,63), (15,30); hist_cnt stays 511; len=16 dist=12 -> (21,1), (4,1).
REQ-041 hist_cnt=4, match dist=6 (or len=7) -> err pulse 1 cycle, sym_vld stays 0, hist_cnt=4.
REQ-042 Match accepted with sym_rdy=0 for 5 cycles -> sym=length code stable, tok_rdy=0.
REQ-043 Continuing REQ-042: sym_rdy then rises -> distance symbol appears next cycle.
REQ-044 rst=1 (and separately en=0) in LEN -> next cycle IDLE, sym_vld=0, hist_cnt=0; no distance symbol ever emitted.
